// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: MAR/MDR, word memory, wait-stated access FSM
// with a one-cycle ready pulse, and the MDR tristate gate onto the shared bus.
module lc3_mem_responder #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             gate_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  output logic             r,
  output logic [WIDTH-1:0] mar,
  output logic [WIDTH-1:0] mdr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                op_q, op_d;
  logic                mem_we, mem_re;
  logic [WIDTH-1:0]    rdata_q;
  logic [WIDTH-1:0]    mem [2**ADDR_W];

  // An x/z enable resolves to x on the bus, which is the wanted behaviour.
  assign bus = gate_mdr ? mdr : {WIDTH{1'bz}};

  // NOTE: every signal gets its default first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mio_en) begin
          addr_d  = mar[ADDR_W-1:0];
          op_d    = r_w;
          cnt_d   = WAIT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!mio_en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = op_q;
          mem_re  = !op_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. the write sees mdr before its own load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      r       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      r       <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar     <= '0;
      mdr     <= '0;
      rdata_q <= '0;
    end else begin
      if (ld_mar) mar <= bus;
      if (ld_mdr) mdr <= mio_en ? rdata_q : bus;
      if (mem_re) rdata_q <= mem[addr_q];
    end
  end

  // NOTE: the memory array has no reset; contents survive rst_n, but reset
  // still blocks a write that would otherwise complete on the same edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[addr_q] <= mdr;
  end

endmodule
